board_store: RTL and testbench

BOARD_STORE -- requirements
Module: board_store

---
 rtl/board_store.sv | 110 +++++++++++
 tb/tb_board_store.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/board_store.sv
// Connect-four style board store: 6x7 grid of 2-bit cells with a drop FSM
// that scans a column bottom-up, and a column-at-a-time clear sequence.
module board_store (
    input  logic       clk,
    input  logic       rst,
    input  logic       drop_req,
    input  logic [2:0] drop_col,
    input  logic [1:0] drop_player,
    input  logic       clear_req,
    output logic       busy,
    output logic       drop_done,
    output logic       drop_ok,
    output logic [2:0] drop_row,
    input  logic [2:0] d_r_row,
    input  logic [2:0] d_r_col,
    input  logic       read_board,
    output logic [1:0] piece_data,
    output logic [6:0] col_full,
    output logic       board_full
);
    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_WRITE, S_DONE, S_CLEAR} state_t;

    state_t                 state_q;
    logic [5:0][6:0][1:0]   board_q;   // [row][col], row 0 = bottom
    logic [2:0]             row_q;
    logic [2:0]             col_q;
    logic [1:0]             player_q;
    logic                   done_q;
    logic                   ok_q;
    logic [2:0]             drop_row_q;

    logic req_valid;
    assign req_valid = (drop_col <= 3'd6) && (drop_player == 2'b01 || drop_player == 2'b10);

    always_ff @(posedge clk) begin
        if (rst) begin
            board_q    <= '0;
            state_q    <= S_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            player_q   <= '0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            drop_row_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (clear_req) begin
                        col_q   <= '0;
                        state_q <= S_CLEAR;
                    end else if (drop_req) begin
                        col_q    <= drop_col;
                        player_q <= drop_player;
                        row_q    <= '0;
                        if (req_valid) begin
                            state_q <= S_SCAN;
                        end else begin
                            ok_q    <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_SCAN: begin
                    if (board_q[row_q][col_q] == 2'b00) begin
                        state_q <= S_WRITE;
                    end else if (row_q < 3'd5) begin
                        row_q <= row_q + 3'd1;
                    end else begin
                        ok_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_WRITE: begin
                    board_q[row_q][col_q] <= player_q;
                    drop_row_q <= row_q;
                    ok_q       <= 1'b1;
                    done_q     <= 1'b1;
                    state_q    <= S_DONE;
                end
                S_DONE: state_q <= S_IDLE;
                S_CLEAR: begin
                    for (int r = 0; r < 6; r++) board_q[r][col_q] <= 2'b00;
                    if (col_q == 3'd6) state_q <= S_IDLE;
                    else               col_q   <= col_q + 3'd1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign drop_done = done_q;
    assign drop_ok   = ok_q;
    assign drop_row  = drop_row_q;

    // Reads see the registered board, so a same-cycle write returns the old value.
    always_comb begin
        piece_data = 2'b00;
        if (read_board && d_r_row <= 3'd5 && d_r_col <= 3'd6)
            piece_data = board_q[d_r_row][d_r_col];
    end

    always_comb begin
        for (int c = 0; c < 7; c++) col_full[c] = (board_q[5][c] != 2'b00);
    end
    assign board_full = &col_full;
endmodule

// File: tb/tb_board_store.sv
// Self-checking bench for board_store: vector table of drops with a scoreboard
// of expected completions, plus hand sequences for clear, ignore-while-busy and reset.
module tb_board_store;
    logic       clk = 1'b0;
    logic       rst, drop_req, clear_req, read_board;
    logic [2:0] drop_col, d_r_row, d_r_col;
    logic [1:0] drop_player;
    logic       busy, drop_done, drop_ok, board_full;
    logic [2:0] drop_row;
    logic [1:0] piece_data;
    logic [6:0] col_full;

    board_store dut (
        .clk(clk), .rst(rst), .drop_req(drop_req), .drop_col(drop_col),
        .drop_player(drop_player), .clear_req(clear_req), .busy(busy),
        .drop_done(drop_done), .drop_ok(drop_ok), .drop_row(drop_row),
        .d_r_row(d_r_row), .d_r_col(d_r_col), .read_board(read_board),
        .piece_data(piece_data), .col_full(col_full), .board_full(board_full)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int done_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (drop_done) done_cnt <= done_cnt + 1;

    int total = 0;
    int bad = 0;

    typedef struct { int ok; int row; int lat; } exp_t;
    exp_t sb[$];

    typedef struct { int col; int player; int ok; int row; int lat; } vec_t;
    vec_t vecs[11];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic read_cell(input int r, input int c, input logic en, output int v);
        d_r_row = r[2:0];
        d_r_col = c[2:0];
        read_board = en;
        #1;
        v = int'(piece_data);
        read_board = 1'b0;
    endtask

    task automatic count_nonzero(output int n);
        int v;
        n = 0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++) begin
                read_cell(r, c, 1'b1, v);
                if (v != 0) n++;
            end
    endtask

    // Drive one drop; optionally pulse a second drop_req while the first is in SCAN.
    task automatic do_drop(input string name, input int col, input int player,
                           input int ok, input int row, input int lat, input bit inject);
        exp_t e, got;
        int n;
        bit seen;
        e.ok = ok; e.row = row; e.lat = lat;
        sb.push_back(e);
        @(posedge clk); #1;
        drop_req = 1'b1; drop_col = col[2:0]; drop_player = player[1:0];
        @(posedge clk); #1;
        n = cyc;
        drop_req = 1'b0;
        if (inject) begin
            drop_req = 1'b1; drop_col = 3'd5; drop_player = 2'b01;
            @(posedge clk); #1;
            drop_req = 1'b0;
        end
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (drop_done) begin
                seen = 1'b1;
                got = sb.pop_front();
                chk({name, "_ok"}, int'(drop_ok), got.ok);
                chk({name, "_row"}, int'(drop_row), got.row);
                chk({name, "_lat"}, cyc - n + 1, got.lat);
                @(negedge clk);
                chk({name, "_pulse"}, int'(drop_done), 0);
            end
        end
        if (!seen) begin
            chk({name, "_timeout"}, 0, 1);
            void'(sb.pop_front());
        end
    endtask

    initial begin
        int v, n, d0, bcnt;
        rst = 1'b1; drop_req = 1'b0; clear_req = 1'b0; read_board = 1'b0;
        drop_col = '0; drop_player = '0; d_r_row = '0; d_r_col = '0;

        vecs[0]  = '{3, 1, 1, 0, 3};
        vecs[1]  = '{3, 2, 1, 1, 4};
        vecs[2]  = '{7, 1, 0, 1, 1};
        vecs[3]  = '{2, 3, 0, 1, 1};
        vecs[4]  = '{0, 1, 1, 0, 3};
        vecs[5]  = '{0, 2, 1, 1, 4};
        vecs[6]  = '{0, 1, 1, 2, 5};
        vecs[7]  = '{0, 2, 1, 3, 6};
        vecs[8]  = '{0, 1, 1, 4, 7};
        vecs[9]  = '{0, 2, 1, 5, 8};
        vecs[10] = '{0, 1, 0, 5, 7};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(drop_done), 0);
        chk("rst_ok", int'(drop_ok), 0);
        chk("rst_row", int'(drop_row), 0);
        chk("rst_colfull", int'(col_full), 0);

        foreach (vecs[i])
            do_drop($sformatf("vec%0d", i), vecs[i].col, vecs[i].player,
                    vecs[i].ok, vecs[i].row, vecs[i].lat, 1'b0);

        read_cell(0, 3, 1'b1, v); chk("cell_0_3", v, 1);
        read_cell(1, 3, 1'b1, v); chk("cell_1_3", v, 2);
        read_cell(0, 2, 1'b1, v); chk("cell_0_2", v, 0);
        read_cell(5, 0, 1'b1, v); chk("cell_5_0", v, 2);
        chk("colfull_c0", int'(col_full), 7'b0000001);
        chk("boardfull_0", int'(board_full), 0);
        read_cell(0, 3, 1'b0, v); chk("rd_disabled", v, 0);
        read_cell(6, 3, 1'b1, v); chk("rd_row6", v, 0);
        read_cell(0, 7, 1'b1, v); chk("rd_col7", v, 0);

        // Second request during SCAN must be dropped on the floor.
        d0 = done_cnt;
        do_drop("midscan", 3, 1, 1, 2, 5, 1'b1);
        repeat (4) @(negedge clk);
        read_cell(0, 5, 1'b1, v); chk("midscan_col5", v, 0);
        chk("midscan_ndone", done_cnt - d0, 1);

        // Clear beats drop when both arrive together.
        d0 = done_cnt;
        @(posedge clk); #1;
        clear_req = 1'b1; drop_req = 1'b1; drop_col = 3'd4; drop_player = 2'b01;
        @(posedge clk); #1;
        clear_req = 1'b0; drop_req = 1'b0;
        bcnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy) bcnt++;
        end
        chk("clear_busy", bcnt, 7);
        chk("clear_nodone", done_cnt - d0, 0);
        count_nonzero(n); chk("clear_cells", n, 0);
        chk("clear_colfull", int'(col_full), 0);

        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 6; r++)
                do_drop($sformatf("fill_%0d_%0d", r, c), c, ((r + c) % 2) + 1, 1, r, r + 3, 1'b0);
        chk("full_board", int'(board_full), 1);
        read_cell(4, 6, 1'b1, v); chk("full_4_6", v, ((4 + 6) % 2) + 1);

        // Reset mid-SCAN: a full-column drop would otherwise finish at N+7.
        d0 = done_cnt;
        @(posedge clk); #1;
        drop_req = 1'b1; drop_col = 3'd2; drop_player = 2'b10;
        @(posedge clk); #1;
        drop_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_full", int'(board_full), 0);
        chk("rst_mid_ok", int'(drop_ok), 0);
        chk("rst_mid_row", int'(drop_row), 0);
        count_nonzero(n); chk("rst_mid_cells", n, 0);
        repeat (10) @(negedge clk);
        chk("rst_mid_nodone", done_cnt - d0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
